// File: rtl/ab_ctrl_pkg.sv
// Shared definitions for the A/B register datapath sequencer:
// 3-bit state encoding and the B-input mux select values.
package ab_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_WAIT_A = 3'd2;
    localparam logic [2:0] ST_XFER_B = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        WAIT_A = ST_WAIT_A,
        XFER_B = ST_XFER_B,
        OUTPUT = ST_OUTPUT,
        DONE   = ST_DONE,
        ERR    = ST_ERR
    } state_t;

    // B-input mux: 0 selects DinA, 1 selects register A
    localparam logic SEL_DIN = 1'b0;
    localparam logic SEL_A   = 1'b1;

endpackage

// File: rtl/ab_wdog.sv
// WAIT_A watchdog for ab_seq_ctrl (only instantiated with AB_SEQ_TIMEOUT_EN).
// Counts consecutive enabled cycles after a clear; expire_o is high on the
// TIMEOUT_CYC-th enabled cycle. The count saturates at its limit.
module ab_wdog #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clock,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count enabled cycles up to the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/ab_seq_ctrl.sv
// Start/done handshaked sequencer for the 4-bit A/B register datapath.
// Each start runs ITER_COUNT passes of (load A, wait Astatus, transfer A->B),
// then pulses out_ctrl and done. Moore outputs decoded from the state only.
// Optional WAIT_A watchdog enabled by the macro AB_SEQ_TIMEOUT_EN.
module ab_seq_ctrl
    import ab_ctrl_pkg::*;
#(
    parameter int ITER_W      = 4,
    parameter int ITER_COUNT  = 3,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clock,
    input  logic rst,
    input  logic start,
    input  logic Astatus,
    output logic ALoad,
    output logic BLoad,
    output logic Muxsel,
    output logic out_ctrl,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [ITER_W-1:0] LAST_PASS = ITER_W'(ITER_COUNT - 1);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] pass_q, pass_d;
    logic              wd_expire;

`ifdef AB_SEQ_TIMEOUT_EN
    ab_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clock    (clock),
        .rst      (rst),
        .clr_i    (state_q == LOAD_A),
        .en_i     (state_q == WAIT_A),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
    // TIMEOUT_CYC only shapes the watchdog; an illegal value builds nothing either way
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // Next-state and pass counter update
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    pass_d  = '0;
                end
            end
            LOAD_A: state_d = WAIT_A;
            WAIT_A: begin
                // Astatus on the expiring cycle still proceeds to the transfer
                if (Astatus) begin
                    state_d = XFER_B;
                end else if (wd_expire) begin
                    state_d = ERR;
                end
            end
            XFER_B: begin
                if (pass_q == LAST_PASS) begin
                    state_d = OUTPUT;
                end else begin
                    pass_d  = pass_q + ITER_W'(1);
                    state_d = LOAD_A;
                end
            end
            OUTPUT:  state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and pass counter registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    // Moore output decode from the state register only
    always_comb begin
        ALoad    = 1'b0;
        BLoad    = 1'b0;
        Muxsel   = SEL_DIN;
        out_ctrl = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            LOAD_A: ALoad = 1'b1;
            XFER_B: begin
                BLoad  = 1'b1;
                Muxsel = SEL_A;
            end
            OUTPUT: out_ctrl = 1'b1;
            DONE:   done = 1'b1;
`ifdef AB_SEQ_TIMEOUT_EN
            ERR:    err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
